// File: rtl/spi_pwm_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pwm_regfile_pkg
//  Purpose  : Shared op codes, control indices, register map indices, FSM
//             state type and a lane-width helper for the SPI PWM register
//             file.
//  Revision : 1.0  initial release
// ============================================================================
package spi_pwm_regfile_pkg;

    // Command byte op field [7:6]
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_CTRL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // CTRL command idx values
    localparam logic [5:0] CTRL_DISABLE = 6'd0;
    localparam logic [5:0] CTRL_ENABLE  = 6'd1;
    localparam logic [5:0] CTRL_COMMIT  = 6'd2;
    localparam logic [5:0] CTRL_CLR_ERR = 6'd3;

    // Register map
    localparam logic [5:0] IDX_CV       = 6'd0;
    localparam logic [5:0] IDX_PRESCALE = 6'd1;
    localparam logic [5:0] IDX_DC_BASE  = 6'd2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1,
        ST_WR_DISCARD = 2'd2,
        ST_READ       = 2'd3
    } state_t;

    // Bits needed to address a byte lane; never less than 1 so single-byte
    // registers still get a legal vector.
    function automatic int lane_width(input int n_bytes);
        return (n_bytes > 1) ? $clog2(n_bytes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pwm_shadow_reg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pwm_shadow_reg
//  Purpose  : One shadow/active register pair. Bytes are written into the
//             shadow copy one lane at a time; commit copies the whole shadow
//             into the active copy in a single edge. The shadow is readable
//             one byte lane at a time.
//  Ports    : i_Clk, i_Rst_L (async, active-low)
//             i_wr_en / i_wr_lane / i_wr_byte : shadow byte-lane write
//             i_commit                       : shadow -> active
//             i_rd_lane / o_rd_byte          : shadow byte read mux
//             o_active                       : active register value
//  Revision : 1.0  initial release
// ============================================================================
module spi_pwm_shadow_reg
    import spi_pwm_regfile_pkg::*;
#(
    parameter  int REG_BYTES = 4,
    localparam int W         = 8 * REG_BYTES,
    localparam int LANE_W    = lane_width(REG_BYTES)
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_wr_en,
    input  logic [LANE_W-1:0] i_wr_lane,
    input  logic [7:0]        i_wr_byte,
    input  logic              i_commit,
    input  logic [LANE_W-1:0] i_rd_lane,
    output logic [7:0]        o_rd_byte,
    output logic [W-1:0]      o_active
);

    logic [W-1:0] r_shadow;
    logic [W-1:0] r_active;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (i_wr_en) begin
                r_shadow[{i_wr_lane, 3'b000} +: 8] <= i_wr_byte;
            end
            if (i_commit) begin
                r_active <= r_shadow;
            end
        end
    end

    assign o_rd_byte = r_shadow[{i_rd_lane, 3'b000} +: 8];
    assign o_active  = r_active;

endmodule
`default_nettype wire

// File: rtl/spi_pwm_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pwm_regfile
//  Purpose  : SPI-side register file for the PWM block. Decodes the byte
//             stream from the SPI slave into WRITE / READ / CTRL commands,
//             keeps shadow and active copies of counter, prescaler and
//             NUM_CH duty registers, and reports protocol errors.
//  Ports    : i_Clk, i_Rst_L (async, active-low)
//             o_RX_DV / o_RX_Byte : byte stream from SPI slave
//             i_TX_DV / i_TX_Byte : read-back byte load to SPI slave
//             counter_value, prescaler, duty_cycle : active registers
//             enable_pwm : PWM enable, o_err : sticky protocol error
//  Revision : 1.0  initial release
// ============================================================================
module spi_pwm_regfile
    import spi_pwm_regfile_pkg::*;
#(
    parameter  int NUM_CH    = 3,
    parameter  int REG_BYTES = 4,
    localparam int W         = 8 * REG_BYTES,
    localparam int NUM_REGS  = NUM_CH + 2,
    localparam int CNT_W     = lane_width(REG_BYTES)
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic                o_RX_DV,
    input  logic [7:0]          o_RX_Byte,
    output logic                i_TX_DV,
    output logic [7:0]          i_TX_Byte,
    output logic [W-1:0]        counter_value,
    output logic [W-1:0]        prescaler,
    output logic [NUM_CH*W-1:0] duty_cycle,
    output logic                enable_pwm,
    output logic                o_err
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(REG_BYTES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_idx;
    logic             r_enable;
    logic             r_err;
    logic             r_tx_dv;
    logic [7:0]       r_tx_byte;

    logic [1:0]       w_op;
    logic [5:0]       w_cmd_idx;
    logic             w_cmd_idx_ok;
    logic             w_at_last;
    logic             w_commit;
    logic [5:0]       w_rd_idx;
    logic [CNT_W-1:0] w_rd_lane;
    logic [7:0]       w_rd_sel;
    logic [NUM_REGS-1:0] w_wr_en;
    logic [7:0]       w_rd_bytes [NUM_REGS];
    logic [W-1:0]     w_active   [NUM_REGS];

    assign w_op      = o_RX_Byte[7:6];
    assign w_cmd_idx = o_RX_Byte[5:0];
    // Compare with one extra bit so NUM_REGS = 64 does not wrap to zero.
    assign w_cmd_idx_ok = ({1'b0, w_cmd_idx} < 7'(NUM_REGS));
    assign w_at_last    = (r_cnt == c_LAST);
    assign w_commit     = (r_state == ST_IDLE) && o_RX_DV &&
                          (w_op == OP_CTRL) && (w_cmd_idx == CTRL_COMMIT);

    // In IDLE the only load is byte 0 of the register named by the incoming
    // READ command; inside READ the next lane after the current count.
    assign w_rd_idx  = (r_state == ST_IDLE) ? w_cmd_idx : r_idx;
    assign w_rd_lane = (r_state == ST_IDLE) ? '0 : (r_cnt + CNT_W'(1));

    // Unmapped indices read back as 0x00.
    always_comb begin
        w_rd_sel = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_idx == 6'(i)) begin
                w_rd_sel = w_rd_bytes[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        assign w_wr_en[g] = (r_state == ST_WRITE) && o_RX_DV && (r_idx == 6'(g));

        spi_pwm_shadow_reg #(
            .REG_BYTES (REG_BYTES)
        ) u_reg (
            .i_Clk     (i_Clk),
            .i_Rst_L   (i_Rst_L),
            .i_wr_en   (w_wr_en[g]),
            .i_wr_lane (r_cnt),
            .i_wr_byte (o_RX_Byte),
            .i_commit  (w_commit),
            .i_rd_lane (w_rd_lane),
            .o_rd_byte (w_rd_bytes[g]),
            .o_active  (w_active[g])
        );
    end

    assign counter_value = w_active[int'(IDX_CV)];
    assign prescaler     = w_active[int'(IDX_PRESCALE)];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_duty
        assign duty_cycle[c*W +: W] = w_active[c + int'(IDX_DC_BASE)];
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_enable  <= 1'b0;
            r_err     <= 1'b0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= 8'h00;
        end else begin
            r_tx_dv <= 1'b0;
            if (o_RX_DV) begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt <= '0;
                        case (w_op)
                            OP_WRITE: begin
                                r_idx <= w_cmd_idx;
                                if (w_cmd_idx_ok) begin
                                    r_state <= ST_WRITE;
                                end else begin
                                    r_err   <= 1'b1;
                                    r_state <= ST_WR_DISCARD;
                                end
                            end
                            OP_READ: begin
                                r_idx     <= w_cmd_idx;
                                r_state   <= ST_READ;
                                r_tx_dv   <= 1'b1;
                                r_tx_byte <= w_rd_sel;
                            end
                            OP_CTRL: begin
                                // Commit itself is the w_commit strobe into
                                // the register instances.
                                case (w_cmd_idx)
                                    CTRL_DISABLE: r_enable <= 1'b0;
                                    CTRL_ENABLE:  r_enable <= 1'b1;
                                    CTRL_COMMIT:  ;
                                    CTRL_CLR_ERR: r_err    <= 1'b0;
                                    default:      r_err    <= 1'b1;
                                endcase
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                    ST_WRITE, ST_WR_DISCARD: begin
                        if (w_at_last) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_READ: begin
                        if (w_at_last) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt     <= r_cnt + CNT_W'(1);
                            r_tx_dv   <= 1'b1;
                            r_tx_byte <= w_rd_sel;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign i_TX_DV    = r_tx_dv;
    assign i_TX_Byte  = r_tx_byte;
    assign enable_pwm = r_enable;
    assign o_err      = r_err;

endmodule
`default_nettype wire

// File: doc/spi_pwm_regfile.md
# spi_pwm_regfile

Parametrised SPI-side register file for the PWM block: decodes the byte stream from the SPI slave into write, read-back and control commands. It holds a shadow and an active copy of the counter, prescaler and NUM_CH duty-cycle registers, so a PWM update applies atomically on commit. It sits between the SPI slave (o_RX_DV/o_RX_Byte in, i_TX_DV/i_TX_Byte out) and the PWM core, and adds read-back and error reporting.

## Interface
- NUM_CH, 3, number of duty-cycle registers; legal 1..62
- REG_BYTES, 4, bytes per register; legal 1..8; W = 8*REG_BYTES
- i_Clk  in  1  clock
- i_Rst_L  in  1  reset, asynchronous, active-low; clock i_Clk
- o_RX_DV  in  1  received-byte strobe from SPI slave, 1-cycle pulse
- o_RX_Byte  in  8  received byte, valid with o_RX_DV
- i_TX_DV  out  1  1-cycle load strobe for i_TX_Byte to SPI slave
- i_TX_Byte  out  8  byte for next MISO transfer
- counter_value  out  W  active counter register
- prescaler  out  W  active prescaler register
- duty_cycle  out  NUM_CH*W  active duty registers, channel c at [c*W +: W]
- enable_pwm  out  1  PWM enable
- o_err  out  1  sticky protocol error

## Operation
- Command byte: op = [7:6], idx = [5:0]. Register idx: 0 counter, 1 prescaler, 2..NUM_CH+1 duty 0..NUM_CH-1. All other idx values are invalid.
- op 00 WRITE idx: the next REG_BYTES data bytes go to shadow[idx], LSB first. Byte k goes to bits [8k+7:8k]. Active registers do not change.
- op 01 READ idx: returns shadow[idx] LSB first. Invalid idx returns 0x00 bytes.
- op 10 CTRL, idx 0 disable, 1 enable, 2 commit (all shadow to all active, same edge), 3 clear o_err. Any other idx sets o_err and has no other effect.
- op 11: reserved. Sets o_err, stays IDLE.
- Invalid idx on WRITE: sets o_err. Enter WR_DISCARD, consume REG_BYTES bytes, write nothing.
- States: IDLE, WRITE, WR_DISCARD, READ. CTRL completes in IDLE. A byte counter 0..REG_BYTES-1 is shared by all states.
- WRITE and WR_DISCARD: each o_RX_DV stores or drops the byte and increments the counter. At count REG_BYTES-1, return to IDLE and clear the counter.
- READ: load byte 0 on entry. Each o_RX_DV is a dummy byte; after the dummy, load the next byte. The dummy at count REG_BYTES-1 returns to IDLE with no load.
- Data bytes are never reinterpreted as commands. A command is only decoded in IDLE.
- Reset: all shadow and active registers are 0, enable_pwm=0, o_err=0, i_TX_DV=0, i_TX_Byte=0x00, state IDLE, counter 0.
- Reset mid-transaction: state returns to IDLE and the remaining bytes of the frame are decoded as commands. The host must re-sync after reset.

## Timing
- All outputs are registered.
- Write byte: shadow updates on the edge sampling o_RX_DV, visible by READ from the next cycle.
- CTRL: enable_pwm, active registers and o_err change on the edge sampling the command's o_RX_DV, visible the next cycle.
- Enable/disable does not imply commit.
- READ: i_TX_DV pulses exactly 1 cycle, one edge after the sampled o_RX_DV (command or dummy). i_TX_Byte holds until the next load.
- o_RX_DV arrives at most once per cycle. Back-to-back o_RX_DV on consecutive cycles must be accepted without loss.
- o_err sets on the edge of the offending command byte. Clear (CTRL idx 3) beats any same-cycle set, which is impossible because commands are serial.

## Structure
- Package spi_pwm_regfile_pkg holds:
  - op codes OP_WRITE/OP_READ/OP_CTRL/OP_RSVD
  - CTRL idx constants
  - IDX_CV=0, IDX_PRESCALE=1, IDX_DC_BASE=2
  - state enum
- Sub-module spi_pwm_shadow_reg (param REG_BYTES): one shadow/active pair with byte-lane write enable, commit input and shadow read-byte mux. Instantiate NUM_CH+2 times.
- Top level holds the FSM, counter, idx decode and TX mux.

## Test plan
- Reset, then WRITE idx0 bytes 0x11,0x22,0x33,0x44 -> counter_value stays 0. After CTRL commit (0x82), counter_value=0x44332211.
- WRITE duty 2 (cmd 0x04, NUM_CH=3) 0xAA,0xBB,0xCC,0xDD, then READ 0x44 plus 4 dummies -> i_TX_Byte sequence 0xDD? No: 0xAA,0xBB,0xCC,0xDD, each with a 1-cycle i_TX_DV.
- CTRL 0x81 -> enable_pwm=1 next cycle. Then 0x80 -> 0. Active registers unchanged throughout.
- WRITE idx 0x3F (invalid) with data 0x81,0x82,0x83,0x84 -> o_err=1, no register changes, data not treated as commands. Then 0x83 -> o_err=0.
- Write prescaler with back-to-back o_RX_DV every cycle, then commit -> prescaler holds exact bytes. A NUM_CH=8, REG_BYTES=2 build passes the same test.
- Assert i_Rst_L low after 2 of 4 WRITE bytes -> all outputs 0 and FSM in IDLE. The next byte 0x81 enables PWM.
